// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequential command issuer for a combinational 4-operation ALU.
//   One instruction is accepted over a valid/ready handshake.
//   It is decoded and executed in exactly one cycle against an
//   8-entry register file. The result is written back and returned
//   on a valid/ready response channel.
//   One instruction takes 3 cycles when the response side applies
//   no backpressure.
//
// Parameters
//   WIDTH          datapath and register width (must be >= 8)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   i_instr_valid  instruction offered
//   o_instr_ready  issuer idle and able to accept an instruction
//   i_instr        16-bit instruction word
//                  {cmd[15:13], rd[12:10], rs1[9:7], rs2[6:4]}
//                  imm8 occupies [7:0]
//   o_alu_opcode   ALU operation: 00 add, 01 sub, 10 mult, 11 nand
//   o_alu_op1      ALU operand 1
//   o_alu_op2      ALU operand 2
//   i_alu_out      ALU result, combinational from o_alu_*
//   o_rsp_valid    response available
//   i_rsp_ready    response consumer ready
//   o_rsp_data     result value
//   o_rsp_err      illegal instruction flag
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [15:0]      i_instr,
    output logic [1:0]       o_alu_opcode,
    output logic [WIDTH-1:0] o_alu_op1,
    output logic [WIDTH-1:0] o_alu_op2,
    input  logic [WIDTH-1:0] i_alu_out,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [2:0] CMD_LOADI = 3'b100;

    state_t           state_r;
    logic [15:0]      instr_r;
    logic [WIDTH-1:0] rf_r [8];
    logic             instr_ready_r;
    logic [1:0]       alu_opcode_r;
    logic [WIDTH-1:0] alu_op1_r;
    logic [WIDTH-1:0] alu_op2_r;
    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_err_r;

    // Field views of the incoming and latched instruction words.
    logic [2:0]       in_cmd_s;
    logic [2:0]       in_rs1_s;
    logic [2:0]       in_rs2_s;
    logic [2:0]       ex_cmd_s;
    logic [2:0]       ex_rd_s;
    logic [WIDTH-1:0] ex_imm_s;

    assign in_cmd_s = i_instr[15:13];
    assign in_rs1_s = i_instr[9:7];
    assign in_rs2_s = i_instr[6:4];
    assign ex_cmd_s = instr_r[15:13];
    assign ex_rd_s  = instr_r[12:10];
    assign ex_imm_s = {{(WIDTH-8){1'b0}}, instr_r[7:0]};

    // r0 is hard-wired to zero on the read side.
    // Writes to it are also suppressed, so it can never hold a non-zero value.
    function automatic logic [WIDTH-1:0] rf_read(input logic [2:0] idx,
                                                 input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if (idx == 3'd0) begin
            res = {WIDTH{1'b0}};
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Issue FSM with register file, ALU drive and response registers.
    // The ALU operands are loaded at the acceptance edge, so they are
    // steady for the whole EXEC cycle and the ALU result settles before
    // the closing edge. Reads use the file contents at acceptance.
    // This is safe because a new instruction is accepted only after the
    // previous writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            instr_r       <= 16'h0000;
            instr_ready_r <= 1'b1;
            alu_opcode_r  <= 2'b00;
            alu_op1_r     <= {WIDTH{1'b0}};
            alu_op2_r     <= {WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= {WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_instr_valid) begin
                        instr_r       <= i_instr;
                        instr_ready_r <= 1'b0;
                        state_r       <= ST_EXEC;
                        if (in_cmd_s[2] == 1'b0) begin
                            alu_opcode_r <= in_cmd_s[1:0];
                            alu_op1_r    <= rf_read(in_rs1_s, rf_r[in_rs1_s]);
                            alu_op2_r    <= rf_read(in_rs2_s, rf_r[in_rs2_s]);
                        end else begin
                            alu_opcode_r <= 2'b00;
                            alu_op1_r    <= {WIDTH{1'b0}};
                            alu_op2_r    <= {WIDTH{1'b0}};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    alu_opcode_r <= 2'b00;
                    alu_op1_r    <= {WIDTH{1'b0}};
                    alu_op2_r    <= {WIDTH{1'b0}};
                    rsp_valid_r  <= 1'b1;
                    state_r      <= ST_RESP;
                    if (ex_cmd_s[2] == 1'b0) begin
                        rsp_data_r <= i_alu_out;
                        rsp_err_r  <= 1'b0;
                        if (ex_rd_s != 3'd0) begin
                            rf_r[ex_rd_s] <= i_alu_out;
                        end
                    end else if (ex_cmd_s == CMD_LOADI) begin
                        rsp_data_r <= ex_imm_s;
                        rsp_err_r  <= 1'b0;
                        if (ex_rd_s != 3'd0) begin
                            rf_r[ex_rd_s] <= ex_imm_s;
                        end
                    end else begin
                        rsp_data_r <= {WIDTH{1'b0}};
                        rsp_err_r  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_r   <= 1'b0;
                        instr_ready_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    instr_ready_r <= 1'b1;
                    rsp_valid_r   <= 1'b0;
                    alu_opcode_r  <= 2'b00;
                    alu_op1_r     <= {WIDTH{1'b0}};
                    alu_op2_r     <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign o_instr_ready = instr_ready_r;
    assign o_alu_opcode  = alu_opcode_r;
    assign o_alu_op1     = alu_op1_r;
    assign o_alu_op2     = alu_op2_r;
    assign o_rsp_valid   = rsp_valid_r;
    assign o_rsp_data    = rsp_data_r;
    assign o_rsp_err     = rsp_err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl with WIDTH = 32.
//   A behavioural 4-operation ALU closes the loop.
//   Expected responses are queued when an instruction is offered.
//   They are popped and compared at the response handshake.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             i_instr_valid;
    logic             o_instr_ready;
    logic [15:0]      i_instr;
    logic [1:0]       o_alu_opcode;
    logic [WIDTH-1:0] o_alu_op1;
    logic [WIDTH-1:0] o_alu_op2;
    logic [WIDTH-1:0] i_alu_out;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [WIDTH-1:0] o_rsp_data;
    logic             o_rsp_err;

    int checks_cnt;
    int fail_cnt;
    logic [WIDTH:0] exp_q [$];

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .i_instr       (i_instr),
        .o_alu_opcode  (o_alu_opcode),
        .o_alu_op1     (o_alu_op1),
        .o_alu_op2     (o_alu_op2),
        .i_alu_out     (i_alu_out),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_err     (o_rsp_err)
    );

    // Behavioural ALU (add/sub/mult/nand, low WIDTH bits).
    always_comb begin
        case (o_alu_opcode)
            2'b00:   i_alu_out = o_alu_op1 + o_alu_op2;
            2'b01:   i_alu_out = o_alu_op1 - o_alu_op2;
            2'b10:   i_alu_out = o_alu_op1 * o_alu_op2;
            2'b11:   i_alu_out = ~(o_alu_op1 & o_alu_op2);
            default: i_alu_out = {WIDTH{1'b0}};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs1, input logic [2:0] rs2);
        return {1'b0, op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [7:0] imm);
        return {3'b100, rd, 2'b00, imm};
    endfunction

    // Offer one instruction at a negedge with the DUT idle.
    // Check the EXEC-cycle ALU drive and the two-edge response latency.
    // Optionally hold the response for 'hold' cycles while offering a
    // competing instruction, then complete the handshake.
    task automatic issue(input logic [15:0] ins, input logic [WIDTH-1:0] ed,
                         input logic ee, input logic [1:0] eop,
                         input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                         input int hold);
        int n;
        logic [WIDTH:0] exp_v;
        exp_q.push_back({ee, ed});
        i_instr       = ins;
        i_instr_valid = 1'b1;
        n = 0;
        while (!o_instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("instr_ready_before_accept", {31'd0, o_instr_ready}, 32'd1);
        @(negedge clk);
        i_instr_valid = 1'b0;
        check_val("exec_instr_ready", {31'd0, o_instr_ready}, 32'd0);
        check_val("exec_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check_val("exec_opcode", {30'd0, o_alu_opcode}, {30'd0, eop});
        check_val("exec_op1", o_alu_op1, e1);
        check_val("exec_op2", o_alu_op2, e2);
        @(negedge clk);
        check_val("resp_valid_latency", {31'd0, o_rsp_valid}, 32'd1);
        check_val("resp_alu_idle", {30'd0, o_alu_opcode} | o_alu_op1 | o_alu_op2, 32'd0);
        for (int h = 0; h < hold; h++) begin
            i_instr       = enc_alu(2'b00, 3'd7, 3'd1, 3'd1);
            i_instr_valid = 1'b1;
            check_val("hold_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
            check_val("hold_rsp_data", o_rsp_data, ed);
            check_val("hold_instr_ready", {31'd0, o_instr_ready}, 32'd0);
            @(negedge clk);
        end
        i_instr_valid = 1'b0;
        i_rsp_ready   = 1'b1;
        check_val("rsp_valid_at_handshake", {31'd0, o_rsp_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check_val("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp_v = exp_q.pop_front();
            check_val("rsp_data", o_rsp_data, exp_v[WIDTH-1:0]);
            check_val("rsp_err", {31'd0, o_rsp_err}, {31'd0, exp_v[WIDTH]});
        end
        @(negedge clk);
        i_rsp_ready = 1'b0;
        check_val("post_hs_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check_val("post_hs_instr_ready", {31'd0, o_instr_ready}, 32'd1);
    endtask

    initial begin
        checks_cnt    = 0;
        fail_cnt      = 0;
        rst_n         = 1'b0;
        i_instr_valid = 1'b0;
        i_instr       = 16'h0000;
        i_rsp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        check_val("reset_rsp_data", o_rsp_data, 32'd0);
        check_val("reset_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        check_val("reset_alu_drive", {30'd0, o_alu_opcode} | o_alu_op1 | o_alu_op2, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("reset_instr_ready", {31'd0, o_instr_ready}, 32'd1);

        // Basic loads and add, with a 5-cycle response hold on the add.
        issue(enc_li(3'd1, 8'd5), 32'd5, 1'b0, 2'b00, 32'd0, 32'd0, 0);
        issue(enc_li(3'd2, 8'd3), 32'd3, 1'b0, 2'b00, 32'd0, 32'd0, 0);
        issue(enc_alu(2'b00, 3'd3, 3'd1, 3'd2), 32'd8, 1'b0, 2'b00, 32'd5, 32'd3, 5);

        // Remaining ALU operations.
        issue(enc_li(3'd1, 8'hFF), 32'h0000_00FF, 1'b0, 2'b00, 32'd0, 32'd0, 0);
        issue(enc_li(3'd2, 8'h0F), 32'h0000_000F, 1'b0, 2'b00, 32'd0, 32'd0, 0);
        issue(enc_alu(2'b01, 3'd4, 3'd2, 3'd1), 32'hFFFF_FF10, 1'b0, 2'b01,
              32'h0000_000F, 32'h0000_00FF, 0);
        issue(enc_alu(2'b10, 3'd5, 3'd1, 3'd1), 32'h0000_FE01, 1'b0, 2'b10,
              32'h0000_00FF, 32'h0000_00FF, 0);
        issue(enc_alu(2'b11, 3'd6, 3'd1, 3'd2), 32'hFFFF_FFF0, 1'b0, 2'b11,
              32'h0000_00FF, 32'h0000_000F, 1);

        // Illegal command must not touch rd (r1 here).
        issue({3'b110, 3'd1, 10'h2AA}, 32'd0, 1'b1, 2'b00, 32'd0, 32'd0, 0);
        issue(enc_alu(2'b00, 3'd7, 3'd1, 3'd0), 32'h0000_00FF, 1'b0, 2'b00,
              32'h0000_00FF, 32'd0, 0);

        // r0 writes are discarded but the response still carries the value.
        issue(enc_li(3'd0, 8'h07), 32'd7, 1'b0, 2'b00, 32'd0, 32'd0, 0);
        issue(enc_alu(2'b00, 3'd7, 3'd0, 3'd0), 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, 0);

        // Reset during RESP aborts the instruction and clears the file.
        i_instr       = enc_alu(2'b00, 3'd3, 3'd1, 3'd2);
        i_instr_valid = 1'b1;
        @(negedge clk);
        i_instr_valid = 1'b0;
        @(negedge clk);
        check_val("abort_resp_valid_before", {31'd0, o_rsp_valid}, 32'd1);
        check_val("abort_rsp_data_before", o_rsp_data, 32'h0000_010E);
        rst_n = 1'b0;
        #1;
        check_val("abort_rsp_valid_drop", {31'd0, o_rsp_valid}, 32'd0);
        check_val("abort_rsp_data_clear", o_rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(enc_alu(2'b00, 3'd3, 3'd1, 3'd2), 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, 0);

        check_val("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
